// File: rtl/borrow_bypass_serial_subtractor_if.sv
// Operand and result handshake bundle for the serial borrow-bypass subtractor.
// The master drives operands and accepts results; the slave is the subtractor.
interface borrow_bypass_serial_subtractor_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Diff;
    logic        Bout;
    logic        Zero;
    logic [3:0]  Bypass;

    modport master (
        output in_valid,
        input  in_ready,
        output A,
        output B,
        output Bin,
        input  out_valid,
        output out_ready,
        input  Diff,
        input  Bout,
        input  Zero,
        input  Bypass
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  A,
        input  B,
        input  Bin,
        output out_valid,
        input  out_ready,
        output Diff,
        output Bout,
        output Zero,
        output Bypass
    );
endinterface

// File: rtl/borrow_bypass_serial_subtractor.sv
// Sequential 16-bit subtractor: Diff = A - B - Bin, one 4-bit borrow-bypass
// nibble per cycle. Operands are captured once at accept; the result is held
// with out_valid until the consumer takes it.
module borrow_bypass_serial_subtractor (
    input  logic                                 clk,
    input  logic                                 rst,
    borrow_bypass_serial_subtractor_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  nibbleIdx_q;
    logic [15:0] operandA_q;
    logic [15:0] operandB_q;
    logic [15:0] diff_q;
    logic [3:0]  bypass_q;
    logic        borrow_q;
    logic        inReady_q;
    logic        outValid_q;

    logic [3:0]  nibbleA;
    logic [3:0]  nibbleB;
    logic [3:0]  propagate;
    logic        ripple;
    logic [3:0]  nibbleDiff_d;
    logic        bypassHit_d;
    logic        borrow_d;

    // One nibble of the subtraction: ripple the borrow through four bits,
    // and skip the ripple result entirely when every bit pair is equal.
    always_comb begin
        nibbleA      = operandA_q[{nibbleIdx_q, 2'b00} +: 4];
        nibbleB      = operandB_q[{nibbleIdx_q, 2'b00} +: 4];
        propagate    = ~(nibbleA ^ nibbleB);
        ripple       = borrow_q;
        nibbleDiff_d = 4'h0;
        for (int i = 0; i < 4; i++) begin
            nibbleDiff_d[i] = nibbleA[i] ^ nibbleB[i] ^ ripple;
            ripple          = (~nibbleA[i] & nibbleB[i])
                            | (ripple & ~(nibbleA[i] ^ nibbleB[i]));
        end
        bypassHit_d = &propagate;
        borrow_d    = bypassHit_d ? borrow_q : ripple;
    end

    // Control FSM plus datapath registers; handshake flags are registered
    // alongside the state so they never depend combinationally on inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            nibbleIdx_q <= 2'd0;
            operandA_q  <= 16'h0000;
            operandB_q  <= 16'h0000;
            diff_q      <= 16'h0000;
            bypass_q    <= 4'h0;
            borrow_q    <= 1'b0;
            inReady_q   <= 1'b1;
            outValid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && inReady_q) begin
                        operandA_q  <= bus.A;
                        operandB_q  <= bus.B;
                        borrow_q    <= bus.Bin;
                        diff_q      <= 16'h0000;
                        bypass_q    <= 4'h0;
                        nibbleIdx_q <= 2'd0;
                        inReady_q   <= 1'b0;
                        state_q     <= CALC;
                    end
                end
                CALC: begin
                    diff_q[{nibbleIdx_q, 2'b00} +: 4] <= nibbleDiff_d;
                    borrow_q                          <= borrow_d;
                    if (bypassHit_d) begin
                        bypass_q[nibbleIdx_q] <= 1'b1;
                    end
                    if (nibbleIdx_q == 2'd3) begin
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        nibbleIdx_q <= nibbleIdx_q + 2'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready && outValid_q) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReady_q;
    assign bus.out_valid = outValid_q;
    assign bus.Diff      = diff_q;
    assign bus.Bout      = borrow_q;
    assign bus.Zero      = (diff_q == 16'h0000);
    assign bus.Bypass    = bypass_q;

endmodule

// File: tb/tb_borrow_bypass_serial_subtractor.sv
// Self-checking bench for the serial borrow-bypass subtractor: reset values,
// a table of known vectors, backpressure, mid-operation reset and a
// back-to-back random run against an arithmetic reference model.
module tb_borrow_bypass_serial_subtractor;

    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;

    borrow_bypass_serial_subtractor_if busIf ();

    borrow_bypass_serial_subtractor dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf.slave)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        zero;
        logic [3:0]  bypass;
    } vec_t;

    vec_t vecs [7];

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference: plain integer subtraction; a nibble bypasses when the
    // operand nibbles are identical.
    task automatic refModel(input logic [15:0] a, input logic [15:0] b, input logic bin,
                            output logic [15:0] diff, output logic bout,
                            output logic zero, output logic [3:0] bypass);
        int result;
        result = int'(a) - int'(b) - int'(bin);
        bout   = (result < 0);
        diff   = 16'(result);
        zero   = (diff == 16'h0000);
        for (int k = 0; k < 4; k++) begin
            bypass[k] = (a[4*k +: 4] == b[4*k +: 4]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand set, then count cycles until out_valid rises.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic bin, output int latency);
        checkOutput("in_ready before accept", 32'(busIf.in_ready), 32'd1);
        busIf.in_valid = 1'b1;
        busIf.A        = a;
        busIf.B        = b;
        busIf.Bin      = bin;
        tick();
        busIf.in_valid = 1'b0;
        busIf.A        = 16'($urandom);
        busIf.B        = 16'($urandom);
        busIf.Bin      = 1'($urandom);
        latency = 0;
        while (!busIf.out_valid && latency < 20) begin
            tick();
            latency++;
        end
    endtask

    task automatic completeHandshake();
        busIf.out_ready = 1'b1;
        tick();
        busIf.out_ready = 1'b0;
        checkOutput("out_valid after handshake", 32'(busIf.out_valid), 32'd0);
        checkOutput("in_ready after handshake", 32'(busIf.in_ready), 32'd1);
    endtask

    initial begin
        int          latency;
        logic [21:0] heldResult;
        logic [15:0] eDiff;
        logic        eBout;
        logic        eZero;
        logic [3:0]  eBypass;
        logic [15:0] qA[$];
        logic [15:0] qB[$];
        logic        qBin[$];
        logic [15:0] nextA;
        logic [15:0] nextB;
        logic        prevReady;
        int          accepts;
        int          results;
        int          cyc;
        int          lastAccept;
        bit          sawValid;

        checkCount = 0;
        passCount  = 0;

        vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 4'b0011};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 4'b1110};
        vecs[2] = '{16'hABCD, 16'hABCD, 1'b1, 16'hFFFF, 1'b1, 1'b0, 4'b1111};
        vecs[3] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1, 4'b1111};
        vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b0000};
        vecs[5] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1, 4'b0000};
        vecs[6] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b0, 4'b0000};

        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b0;
        busIf.A         = 16'h0000;
        busIf.B         = 16'h0000;
        busIf.Bin       = 1'b0;
        rst             = 1'b1;
        tick();
        tick();
        checkOutput("reset in_ready", 32'(busIf.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("reset Diff", 32'(busIf.Diff), 32'h0000);
        checkOutput("reset Bout", 32'(busIf.Bout), 32'd0);
        checkOutput("reset Zero", 32'(busIf.Zero), 32'd1);
        checkOutput("reset Bypass", 32'(busIf.Bypass), 32'h0);
        rst = 1'b0;
        tick();

        // Known vectors with hand-derived results.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, latency);
            checkOutput($sformatf("vec%0d latency", i), 32'(latency), 32'd4);
            checkOutput($sformatf("vec%0d Diff", i), 32'(busIf.Diff), 32'(vecs[i].diff));
            checkOutput($sformatf("vec%0d Bout", i), 32'(busIf.Bout), 32'(vecs[i].bout));
            checkOutput($sformatf("vec%0d Zero", i), 32'(busIf.Zero), 32'(vecs[i].zero));
            checkOutput($sformatf("vec%0d Bypass", i), 32'(busIf.Bypass), 32'(vecs[i].bypass));
            completeHandshake();
        end

        // Backpressure: result held, new operands refused while DONE.
        applyStimulus(16'h1234, 16'h0034, 1'b0, latency);
        checkOutput("bp latency", 32'(latency), 32'd4);
        heldResult     = {busIf.Diff, busIf.Bout, busIf.Zero, busIf.Bypass};
        checkOutput("bp initial result", 32'(heldResult), 32'({16'h1200, 1'b0, 1'b0, 4'b0011}));
        busIf.in_valid = 1'b1;
        busIf.A        = 16'hFFFF;
        busIf.B        = 16'h0001;
        busIf.Bin      = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checkOutput("bp held result", 32'({busIf.Diff, busIf.Bout, busIf.Zero, busIf.Bypass}), 32'(heldResult));
            checkOutput("bp in_ready low", 32'(busIf.in_ready), 32'd0);
            checkOutput("bp out_valid high", 32'(busIf.out_valid), 32'd1);
        end
        busIf.in_valid = 1'b0;
        completeHandshake();
        tick();
        checkOutput("bp no spurious accept", 32'(busIf.in_ready), 32'd1);

        // Reset while the third nibble is being computed.
        busIf.in_valid = 1'b1;
        busIf.A        = 16'h5A5A;
        busIf.B        = 16'h1234;
        busIf.Bin      = 1'b1;
        tick();
        busIf.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("abort in_ready", 32'(busIf.in_ready), 32'd1);
        checkOutput("abort Diff", 32'(busIf.Diff), 32'h0000);
        checkOutput("abort Bypass", 32'(busIf.Bypass), 32'h0);
        sawValid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (busIf.out_valid) sawValid = 1'b1;
        end
        checkOutput("abort no result", 32'(sawValid), 32'd0);

        // Back-to-back random operations with in_valid and out_ready high.
        accepts         = 0;
        results         = 0;
        cyc             = 0;
        lastAccept      = 0;
        nextA           = 16'($urandom);
        nextB           = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 1) == 1) nextB[4*k +: 4] = nextA[4*k +: 4];
        end
        busIf.A         = nextA;
        busIf.B         = nextB;
        busIf.Bin       = 1'($urandom);
        busIf.in_valid  = 1'b1;
        busIf.out_ready = 1'b1;
        prevReady       = busIf.in_ready;
        while ((accepts < 20 || results < 20) && cyc < 300) begin
            tick();
            cyc++;
            if (prevReady && busIf.in_valid) begin
                qA.push_back(busIf.A);
                qB.push_back(busIf.B);
                qBin.push_back(busIf.Bin);
                if (accepts > 0) begin
                    checkOutput("rand accept spacing", 32'(cyc - lastAccept), 32'd6);
                end
                lastAccept = cyc;
                accepts++;
                nextA = 16'($urandom);
                nextB = 16'($urandom);
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 1) == 1) nextB[4*k +: 4] = nextA[4*k +: 4];
                end
                busIf.A   = nextA;
                busIf.B   = nextB;
                busIf.Bin = 1'($urandom);
                if (accepts == 20) busIf.in_valid = 1'b0;
            end
            if (busIf.out_valid) begin
                if (qA.size() == 0) begin
                    checkOutput("rand unexpected result", 32'd1, 32'd0);
                end else begin
                    refModel(qA.pop_front(), qB.pop_front(), qBin.pop_front(), eDiff, eBout, eZero, eBypass);
                    checkOutput("rand Diff", 32'(busIf.Diff), 32'(eDiff));
                    checkOutput("rand Bout", 32'(busIf.Bout), 32'(eBout));
                    checkOutput("rand Zero", 32'(busIf.Zero), 32'(eZero));
                    checkOutput("rand Bypass", 32'(busIf.Bypass), 32'(eBypass));
                    results++;
                end
            end
            prevReady = busIf.in_ready;
        end
        checkOutput("rand all results seen", 32'(results), 32'd20);
        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/borrow_bypass_serial_subtractor.md
# borrow_bypass_serial_subtractor

Sequential 16-bit subtractor computing Diff = A − B − Bin over four cycles, one 4-bit borrow-bypass block per cycle. It is the subtract-direction companion to the team's 16-bit carry-bypass adder. It sits in datapaths where area matters more than single-cycle latency. Operands enter and results leave through independent valid/ready handshakes.

## Interface
- No parameters; width fixed at 16 bits, block size fixed at 4 bits.
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand set A/B/Bin valid
- in_ready  output  1  block can accept operands
- A  input  16  minuend
- B  input  16  subtrahend
- Bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- Diff  output  16  A − B − Bin modulo 2^16
- Bout  output  1  final borrow; 1 iff A < B + Bin (unsigned)
- Zero  output  1  Diff == 16'h0000
- Bypass  output  4  bit k = nibble k took the bypass path

## Operation
- FSM states: IDLE, CALC, DONE. A 2-bit nibble index idx is used in CALC.
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready: latch A, B and Bin; clear Diff and Bypass; set idx = 0; go to CALC.
- CALC (in_ready = 0, out_valid = 0), nibble k = idx:
  - Pk = ~(A[4k+3:4k] ^ B[4k+3:4k]), per-bit equality.
  - Ripple borrow within the nibble: d = a ^ b ^ bi; bo = (~a & b) | (bi & ~(a ^ b)).
  - If &Pk: borrow out = borrow in (bypass) and Bypass[k] = 1. Otherwise borrow out = ripple result.
  - Register Diff nibble k and the running borrow.
  - idx = 3 goes to DONE; otherwise idx increments.
- DONE
  - out_valid = 1. Diff, Bout, Zero and Bypass are held stable.
  - On out_valid & out_ready: go to IDLE.
- Operands are sampled only at the accepting edge. Changes on A/B/Bin during CALC or DONE are ignored.
- in_valid during CALC or DONE is ignored; there is no queueing.
- Zero is decoded from the registered Diff and is meaningful only while out_valid = 1.
- Arithmetic is unsigned and wraps modulo 2^16. Bout reports the wrap.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, Diff 0, Bout 0, Zero 1 (decoded from Diff = 0), Bypass 0.
- rst takes priority over every handshake on the same edge.
- Accept at edge t. Nibbles 0..3 are written at edges t+1..t+4. out_valid = 1 from edge t+4.
- Latency is 4 cycles, accept edge to out_valid.
- With out_ready held at 1, the result handshake occurs at edge t+5 and in_ready = 1 from t+5. The next accept is at t+6, so back-to-back throughput is one operation per 6 cycles.
- Backpressure: out_valid and all result outputs hold indefinitely until out_ready; in_ready stays 0.
- Reset mid-operation (CALC or DONE): the operation is discarded, no out_valid is produced, and the block is in IDLE with in_ready = 1 after the reset edge.
- in_ready and out_valid are decoded from the state register only, with no combinational path from in_valid or out_ready.

## Test plan
- A=16'h1234, B=16'h0034, Bin=0 -> after 4 cycles: Diff=16'h1200, Bout=0, Zero=0, Bypass=4'b0011.
- A=16'h0000, B=16'h0001, Bin=0 -> Diff=16'hFFFF, Bout=1, Zero=0, Bypass=4'b1110.
- A=B=16'hABCD, Bin=1 -> Diff=16'hFFFF, Bout=1, Bypass=4'b1111 (borrow bypassed end to end). Same operands with Bin=0 -> Diff=0, Zero=1, Bout=0, Bypass=4'b1111.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> Diff/Bout/Zero/Bypass unchanged, in_ready=0, and a concurrent in_valid with new operands is not accepted. Raise out_ready -> handshake, then in_ready=1 next cycle.
- Assert rst for one cycle while idx=2 -> next cycle: state IDLE, out_valid=0, in_ready=1, Diff=0. No result is ever emitted for the aborted operation.
- in_valid and out_ready tied high with 20 random operand sets -> accepts spaced exactly 6 cycles apart; each result matches the reference model (A−B−Bin) mod 2^16 with the correct Bout.
